dmem_responder: RTL and testbench

//  Memory-side responder for the core's data-memory port.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_byte_array.sv | 43 ++++
 rtl/dmem_responder.sv | 123 ++++++++++++
 tb/tb_dmem_responder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states,
// the full-word byte-enable constant and byte-enable to bit-mask expansion.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Little-endian byte storage, one 32-bit word port: combinational read,
// byte-enabled synchronous write. Contents are never reset.
module dmem_byte_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned WORD_AW     = 8
) (
    input  logic               i_clk,
    input  logic [WORD_AW-1:0] i_word_addr,
    input  logic [31:0]        i_wdata,
    input  logic [3:0]         i_be,
    input  logic               i_we,
    output logic [31:0]        o_rdata
);

    localparam int unsigned BAW = WORD_AW + 2;

    logic [7:0]     r_mem [DEPTH_BYTES];
    logic [BAW-1:0] w_idx [4];
    logic [31:0]    w_new;

    // Bytes are held XORed with their index, so zero-initialised simulation
    // storage reads back as the mem[i] = i[7:0] preload pattern.
    always_comb begin
        o_rdata = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_idx[i]          = {i_word_addr, 2'(i)};
            o_rdata[8*i +: 8] = r_mem[w_idx[i]] ^ 8'(w_idx[i]);
        end
    end

    assign w_new = (o_rdata & ~be_mask(i_be)) | (i_wdata & be_mask(i_be));

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                r_mem[w_idx[i]] <= w_new[8*i +: 8] ^ 8'(w_idx[i]);
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency valid/ready data-memory responder for the core's load/store port.
// Optional DMEM_MISALIGN_CHECK_EN: faults any access with req_addr[1:0] != 0.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned BAW     = $clog2(DEPTH_BYTES);
    localparam int unsigned WORD_AW = BAW - 2;
    localparam int unsigned CW      = $clog2(LATENCY + 1);

    state_t             r_state, w_next;
    logic               r_req_ready;
    logic [CW-1:0]      r_cnt;
    logic               r_we, r_err;
    logic [WORD_AW-1:0] r_word;
    logic [31:0]        r_wdata;
    logic [3:0]         r_be;
    logic               r_rsp_valid, r_rsp_err;
    logic [31:0]        r_rsp_rdata;

    logic               w_accept, w_rsp_done, w_commit;
    logic               w_range_err, w_req_err;
    logic [31:0]        w_mem_rdata;

    assign w_accept   = req_valid & r_req_ready;
    assign w_rsp_done = r_rsp_valid & rsp_ready;
    assign w_commit   = (r_state == WAIT) && (w_next == RESP);

    // Last byte of the addressed word, in 33 bits so high addresses cannot wrap.
    assign w_range_err = ({1'b0, req_addr} | 33'd3) > 33'(DEPTH_BYTES - 1);
`ifdef DMEM_MISALIGN_CHECK_EN
    assign w_req_err = w_range_err | (req_addr[1:0] != 2'b00);
`else
    assign w_req_err = w_range_err;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = WAIT;
            WAIT:    if (r_cnt == '0) w_next = RESP;
            RESP:    if (w_rsp_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // WAIT always spans LATENCY edges (cnt counts LATENCY-1 down to 0), so
    // RESP is entered exactly LATENCY edges after accept, including LATENCY=1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req_ready <= 1'b0;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_word      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_req_ready <= (w_next == IDLE);
            if (w_accept) begin
                r_we    <= req_we;
                r_err   <= w_req_err;
                r_word  <= req_addr[BAW-1:2];
                r_wdata <= req_wdata;
                r_be    <= req_we ? req_be : BE_WORD;
                r_cnt   <= CW'(LATENCY - 1);
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_commit) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= r_err;
                r_rsp_rdata <= (r_we || r_err) ? '0 : w_mem_rdata;
            end else if (w_rsp_done) begin
                r_rsp_valid <= 1'b0;
                r_rsp_err   <= 1'b0;
                r_rsp_rdata <= '0;
            end
        end
    end

    dmem_byte_array #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .WORD_AW     (WORD_AW)
    ) u_mem (
        .i_clk       (clk),
        .i_word_addr (r_word),
        .i_wdata     (r_wdata),
        .i_be        (r_be),
        .i_we        (w_commit & r_we & ~r_err),
        .o_rdata     (w_mem_rdata)
    );

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a driver pushes expected responses from a
// byte-array reference model; a negedge monitor pops and checks them.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [31:0] rsp_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    logic [7:0]  ref_mem [DEPTH];
    int          cyc = 0;
    int          compared = 0, mismatched = 0;
    int          rdy_mode = 0;
    bit          in_resp = 0, exp_ready_next = 0;

    dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = ($urandom_range(0, 2) != 0);
            default: rsp_ready = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: timed out waiting, expected event within bound (t=%0t)", name, $time);
    endtask

    // Reference: word-aligned access, fault when the word's last byte is past the end.
    task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output logic [31:0] rdata, output logic err);
        longint unsigned base;
        base  = longint'(addr) & 64'hFFFF_FFFC;
        err   = (base + 3) > (DEPTH - 1);
`ifdef DMEM_MISALIGN_CHECK_EN
        if (addr[1:0] != 2'b00) err = 1'b1;
`endif
        rdata = '0;
        if (!err) begin
            for (int b = 0; b < 4; b++) begin
                if (we && be[b]) ref_mem[base + b] = wdata[8*b +: 8];
                if (!we) rdata[8*b +: 8] = ref_mem[base + b];
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
        exp_t e;
        int   n = 0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        while (!req_ready) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                fail_timeout("req_accept");
                req_valid = 1'b0;
                return;
            end
        end
        model(we, addr, wdata, be, e.rdata, e.err);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_we = $urandom_range(0, 1); req_addr = $urandom(); req_wdata = $urandom();
        req_be = 4'($urandom());
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || in_resp || rsp_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_timeout("drain");
        @(negedge clk);
    endtask

    task automatic wait_rsp_valid(input string name);
        int n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) fail_timeout(name);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            in_resp        = 0;
            exp_ready_next = 0;
        end else begin
            if (exp_ready_next) chk("ready_after_rsp", 32'(req_ready), 32'd1);
            exp_ready_next = 0;
            if (rsp_valid) begin
                if (!in_resp) begin
                    if (sb.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_rsp: got rsp_valid=1, expected no response");
                    end else begin
                        cur = sb.pop_front();
                        chk("rsp_rdata", rsp_rdata, cur.rdata);
                        chk("rsp_err", 32'(rsp_err), 32'(cur.err));
                        chk("latency", 32'(cyc), 32'(cur.acc + int'(LAT)));
                    end
                    in_resp = 1;
                end else begin
                    chk("hold_rdata", rsp_rdata, cur.rdata);
                    chk("hold_err", 32'(rsp_err), 32'(cur.err));
                end
                chk("ready_during_rsp", 32'(req_ready), 32'd0);
                if (rsp_ready) begin
                    in_resp        = 0;
                    exp_ready_next = 1;
                end
            end else begin
                chk("idle_rdata", rsp_rdata, 32'd0);
                chk("idle_err", 32'(rsp_err), 32'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 8'(i);

        // Reset held for three cycles: everything quiet, then ready one edge after release.
        repeat (3) begin
            @(negedge clk);
            chk("rst_valid", 32'(rsp_valid), 32'd0);
            chk("rst_rdata", rsp_rdata, 32'd0);
            chk("rst_err", 32'(rsp_err), 32'd0);
            chk("rst_ready", 32'(req_ready), 32'd0);
        end
        #2 rst = 1'b1;
        #1 chk("ready_at_release", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("ready_after_reset", 32'(req_ready), 32'd1);

        rdy_mode = 0;
        issue(1'b0, 32'h10, '0, 4'h0);
        issue(1'b1, 32'h20, 32'hDEAD_BEEF, 4'b0101);
        issue(1'b0, 32'h20, '0, 4'h0);
        drain();

        // Backpressure with a second request already waiting.
        rdy_mode = 2;
        fork
            issue(1'b0, 32'h40, '0, 4'h0);
            begin
                @(negedge clk);
                wait_rsp_valid("rsp_hold_start");
                repeat (3) @(negedge clk);
                rdy_mode = 0;
            end
        join
        issue(1'b0, 32'h44, '0, 4'h0);
        drain();

        issue(1'b0, 32'h3FE, '0, 4'h0);
        issue(1'b0, 32'h3FC, '0, 4'h0);
        issue(1'b0, 32'hFFFF_FFFC, '0, 4'h0);
        issue(1'b1, 32'h21, 32'h1234_5678, 4'hF);
        issue(1'b0, 32'h20, '0, 4'h0);
        issue(1'b0, 32'h21, '0, 4'h0);
        issue(1'b1, 32'h24, 32'hFFFF_FFFF, 4'b0000);
        issue(1'b0, 32'h24, '0, 4'h0);
        drain();

        // Reset during WAIT drops an uncommitted store.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hFFFF_FFFF; req_be = 4'hF;
        wait (req_ready);
        @(negedge clk);
        req_valid = 1'b0;
        #2 rst = 1'b0;
        #1 chk("abort_wait_valid", 32'(rsp_valid), 32'd0);
        chk("abort_wait_ready", 32'(req_ready), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        issue(1'b0, 32'h30, '0, 4'h0);
        drain();

        // Reset while a response is being held drops rsp_valid asynchronously.
        rdy_mode = 2;
        issue(1'b0, 32'h50, '0, 4'h0);
        wait_rsp_valid("abort_resp_start");
        #2 rst = 1'b0;
        #1 chk("abort_resp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_resp_rdata", rsp_rdata, 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rdy_mode = 0;
        #2 rst = 1'b1;
        @(negedge clk);

        rdy_mode = 1;
        for (int t = 0; t < 300; t++) begin
            logic [31:0] a;
            case ($urandom_range(0, 9))
                0:       a = $urandom();
                1:       a = 32'($urandom_range(DEPTH - 8, DEPTH - 1));
                default: a = 32'($urandom_range(0, DEPTH - 1));
            endcase
            issue(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom()));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rdy_mode = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
